// File: rtl/inst_queue_if.sv
// Fetch->queue->decode handshake bundle for inst_queue.
// The queue uses the slave modport; the fetch/decode side uses master.
interface inst_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_adel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;

    modport slave (
        input  in_valid, in_pc, in_inst, in_adel, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_adel
    );

    modport master (
        output in_valid, in_pc, in_inst, in_adel, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_adel
    );
endinterface

// File: rtl/inst_queue.sv
// Instruction fetch queue between fetch and decode: circular buffer of {pc, inst, adel}.
// Define INST_QUEUE_BYPASS_EN to pass an entry straight through when the queue is empty.
module inst_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    inst_queue_if.slave   q,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [31:0]      mem_pc   [DEPTH];
    logic [31:0]      mem_inst [DEPTH];
    logic [DEPTH-1:0] mem_adel;

    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    logic full;
    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic consume;
    logic wr;
    logic rd;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // A pop while full frees the slot only from the next cycle on.
    assign q.in_ready = !full && !flush && !rst;

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = empty && q.in_valid && !flush && !rst;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        q.out_valid = (!empty && !flush) || bypass;
        if (bypass) begin
            q.out_pc   = q.in_pc;
            q.out_inst = q.in_inst;
            q.out_adel = q.in_adel;
        end else begin
            q.out_pc   = mem_pc[head];
            q.out_inst = mem_inst[head];
            q.out_adel = mem_adel[head];
        end
        if (!q.out_valid) begin
            q.out_inst = '0;
        end
    end

    assign push    = q.in_valid && q.in_ready;
    assign pop     = q.out_valid && q.out_ready;
    // A bypassed word taken by decode in the same cycle never touches storage.
    assign consume = bypass && q.out_ready;
    assign wr      = push && !consume;
    assign rd      = pop && !consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            mem_adel <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                mem_pc[tail]   <= q.in_pc;
                mem_inst[tail] <= q.in_inst;
                mem_adel[tail] <= q.in_adel;
                tail           <= tail + AW'(1);
            end
            if (rd) begin
                head <= head + AW'(1);
            end
            case ({wr, rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction fetch queue between the fetch stage and the decode stage of the MIPS core. It buffers up to DEPTH fetched words with their PC and fetch-exception flag, so fetch can run ahead of decode stalls. It presents the oldest entry to decode, where `out_inst` drives the instruction-recognition logic directly. A single-cycle flush empties it on branch redirect, exception or `eret`.

## Interface
Parameters:
- `DEPTH`, default 8: number of entries; power of two, at least 2.
- `AW`, default 3: pointer width; must equal log2(DEPTH).

Ports:
- `clk`  in  1  single core clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  discard all entries this cycle (redirect, exception, eret).
- `in_valid`  in  1  fetch offers an entry.
- `in_ready`  out  1  queue accepts an entry this cycle.
- `in_pc`  in  32  PC of the offered word.
- `in_inst`  in  32  fetched instruction word.
- `in_adel`  in  1  fetch address-error flag (PC not word-aligned).
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  decode consumes the head this cycle.
- `out_pc`  out  32  PC of head entry.
- `out_inst`  out  32  instruction of head entry; 0 when `out_valid`=0.
- `out_adel`  out  1  address-error flag of head entry.
- `count`  out  AW+1  number of stored entries, 0..DEPTH.

## Operation
- Storage is a circular buffer with `head` and `tail` pointers, each AW bits, that wrap modulo DEPTH. `count` is a separate AW+1-bit register.
- Push: `in_valid & in_ready` writes {pc, inst, adel} at `tail` and sets tail to tail+1.
- Pop: `out_valid & out_ready` sets head to head+1.
- Simultaneous push and pop: both pointers advance and `count` is unchanged.
- `in_ready` = (`count` != DEPTH) & !`flush` & !`rst`. When full, a same-cycle pop does not open a slot; it becomes visible the next cycle.
- `out_valid` = (`count` != 0) & !`flush`.
- `out_pc`, `out_inst` and `out_adel` are read combinationally from the head entry.
- `out_inst` is forced to 32'h0 (sll $0, i.e. nop) when `out_valid`=0, so decode never sees stale words.
- Flush has priority over push and pop in the same cycle. On flush: head = tail = 0, `count` = 0, and no write takes place. The stored data is left as is (don't-care).
- The queue does not interpret instructions. Delay-slot handling belongs to fetch, which must re-present the delay slot after the flush.

## Timing
- Reset (asynchronous, takes effect immediately): head = 0, tail = 0, `count` = 0, `in_ready` = 0, `out_valid` = 0, `out_inst` = 0, `out_pc` = 0, `out_adel` = 0.
- First cycle after `rst` falls: `in_ready` = 1.
- Push-to-visible latency: an entry pushed at edge N is presented with `out_valid`=1 in the cycle after edge N. This is 1 cycle when bypass is compiled out.
- Full boundary: `count`=DEPTH drives `in_ready`=0. Fetch must hold `in_pc`, `in_inst` and `in_adel` stable until accepted.
- Empty boundary: `count`=0 drives `out_valid`=0. An `out_ready` asserted while empty has no effect.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble.
- Reset asserted mid-operation discards all entries asynchronously.
- Flush asserted together with `in_valid`: the word is dropped (`in_ready`=0) and fetch must not count it as accepted.

## Configuration
- `INST_QUEUE_BYPASS_EN` defined:
  - When `count`=0, `in_valid`=1 and `flush`=0, the input is passed combinationally to `out_*` with `out_valid`=1.
  - If `out_ready`=1 in that cycle, the entry is consumed without being written: pointers and `count` are unchanged.
  - If `out_ready`=0, it is written normally.
  - Empty-queue latency is 0 cycles.
- Not defined: no combinational path from `in_*` to `out_*`; minimum latency is 1 cycle.

## Test plan
- Reset then idle: after `rst` 1->0, check `in_ready`=1, `out_valid`=0, `out_inst`=32'h0 and `count`=0.
- Push 3 words (pc 0xBFC00000/04/08, inst 0x24080001/0x3C09BFC0/0x00000000) with `out_ready`=0: `count`=3 and head shows pc 0xBFC00000, inst 0x24080001. Then pop 3 in consecutive cycles: they come out in order and `count` returns to 0.
- Fill to DEPTH=8 with `out_ready`=0: `in_ready`=0 once `count`=8. Then assert `in_valid`+`out_ready` for one cycle: the pop occurs, no push occurs, and `count`=7.
- Continuous push and pop for 20 cycles starting at `count`=2: `count` stays at 2, the PC sequence is gap-free across pointer wrap, and `in_adel`=1 on the pc 0xBFC00013 entry appears on `out_adel` for that entry only.
- Flush with `count`=5 and `in_valid`=1 in the same cycle: the next cycle shows `count`=0 and `out_valid`=0, and the flushed-cycle word is not stored.
- With `INST_QUEUE_BYPASS_EN` defined: empty queue, `in_valid`=`out_ready`=1, inst 0x8D090004. Same cycle: `out_valid`=1 and `out_inst`=0x8D090004. Next cycle: `count`=0. Without the macro, `out_valid`=0 in the first cycle and 1 in the next.
